// File: rtl/prog_loader_pkg.sv
// Shared definitions for the byte-stream program loader: FSM state
// encoding, default frame-start byte and frame-length helpers.
// Optional feature macro used by the loader: PROG_LOADER_CHECKSUM_EN.
package prog_loader_pkg;

  // Default frame-start byte.
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // A length byte of 0 encodes a full 256-word frame.
  localparam int FRAME_MAX_WORDS = 256;

  // Width of the remaining-word counter (must hold 256).
  localparam int COUNT_W = 9;

  // Loader FSM states. CHECK and ERROR are only reachable when the
  // checksum feature is built in.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_DATA_HI = 3'd2,
    ST_DATA_LO = 3'd3,
    ST_WRITE   = 3'd4,
    ST_CHECK   = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERROR   = 3'd7
  } state_t;

  // Convert the frame length byte L into a word count N.
  function automatic logic [COUNT_W-1:0] len_to_words(input logic [7:0] len);
    if (len == 8'd0) begin
      return COUNT_W'(FRAME_MAX_WORDS);
    end
    return {1'b0, len};
  endfunction

endpackage

// File: rtl/loader_xor_acc.sv
// 8-bit XOR accumulator used for the frame checksum. Clear has priority
// over accumulate so a new frame always starts from zero.
module loader_xor_acc (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] acc
);

  logic [7:0] acc_q;

  // Running XOR of every enabled byte since the last clear.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_q <= 8'd0;
    end else if (en) begin
      acc_q <= acc_q ^ din;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader. Receives framed bytes (sync, length, data
// pairs high byte first, optional checksum), assembles 16-bit words and
// writes them sequentially from address 0 into instruction memory while
// holding the CPU in reset.
//
// Byte handshake: a byte transfers on a rising clk edge when
// in_valid && in_ready; the source must hold in_data/in_valid stable
// while in_ready is low. in_ready is decoded from the state register only.
//
// Build option: define PROG_LOADER_CHECKSUM_EN to add the trailing
// checksum byte, the CHECK/ERROR states and the sticky error output.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter int         DATA_W    = 16,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output state_t            state_dbg
);

  localparam logic [ADDR_W-1:0]  ADDR_ONE  = ADDR_W'(1);
  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [COUNT_W-1:0]  count_q;
  logic [7:0]          hi_q;
  logic [7:0]          lo_q;

  logic                xfer;
  logic                is_sync;
  logic                start;

  assign xfer    = in_valid && in_ready;
  assign is_sync = (in_data == SYNC_BYTE);
  // A sync byte starts a new load from IDLE or from ERROR.
  assign start   = xfer && is_sync && ((state_q == ST_IDLE) || (state_q == ST_ERROR));

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_en;

  // Length and data bytes feed the checksum; the sync byte does not.
  assign csum_en = xfer && ((state_q == ST_LEN) ||
                            (state_q == ST_DATA_HI) ||
                            (state_q == ST_DATA_LO));

  loader_xor_acc u_xor_acc (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .en  (csum_en),
    .din (in_data),
    .acc (csum)
  );
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; input gaps leave the state unchanged.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (xfer) begin
          state_d = ST_DATA_HI;
        end
      end
      ST_DATA_HI: begin
        if (xfer) begin
          state_d = ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (xfer) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (count_q == COUNT_ONE) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_DATA_HI;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (xfer) begin
          state_d = (in_data == csum) ? ST_DONE : ST_ERROR;
        end
      end
      ST_ERROR: begin
        if (start) begin
          state_d = ST_LEN;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Address counter, remaining-word count and byte latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      count_q <= '0;
      hi_q    <= 8'd0;
      lo_q    <= 8'd0;
    end else begin
      if (start) begin
        addr_q <= '0;
      end
      if (xfer && (state_q == ST_LEN)) begin
        count_q <= len_to_words(in_data);
      end
      if (xfer && (state_q == ST_DATA_HI)) begin
        hi_q <= in_data;
      end
      if (xfer && (state_q == ST_DATA_LO)) begin
        lo_q <= in_data;
      end
      if (state_q == ST_WRITE) begin
        addr_q  <= addr_q + ADDR_ONE;
        count_q <= count_q - COUNT_ONE;
      end
    end
  end

  // Outputs are decoded from the state and datapath registers only.
  assign in_ready   = !((state_q == ST_WRITE) || (state_q == ST_DONE));
  assign imem_we    = (state_q == ST_WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = {hi_q, lo_q};
  assign cpu_hold   = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign state_dbg  = state_q;

`ifdef PROG_LOADER_CHECKSUM_EN
  assign error = (state_q == ST_ERROR);
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: directed frames from the test plan plus
// randomized frames with random input gaps, checked against a
// frame-level model (expected write queue and expected memory image).
module tb_prog_loader;

  logic                          clk;
  logic                          rst;
  logic [7:0]                    in_data;
  logic                          in_valid;
  logic                          in_ready;
  logic                          imem_we;
  logic [7:0]                    imem_addr;
  logic [15:0]                   imem_wdata;
  logic                          cpu_hold;
  logic                          done;
  logic                          error;
  prog_loader_pkg::state_t       state_dbg;

  int n_vec;
  int n_err;
  int done_cnt;

  // Scoreboard: expected {addr, data} writes in order.
  logic [23:0] exp_q[$];
  logic [15:0] exp_mem[256];
  bit          exp_wr[256];
  logic [15:0] dut_mem[256];
  logic [15:0] fr_words[256];

  prog_loader u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .state_dbg  (state_dbg)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: memory writes against the scoreboard, done pulses, and
  // in_ready low exactly while a write or done cycle is shown.
  always @(negedge clk) begin
    if (imem_we) begin
      dut_mem[imem_addr] = imem_wdata;
      if (exp_q.size() == 0) begin
        check_val("unexpected_write", {8'd0, imem_addr, imem_wdata}, 32'd0);
      end else begin
        check_val("write", {8'd0, imem_addr, imem_wdata}, {8'd0, exp_q.pop_front()});
      end
    end
    if (done) done_cnt++;
    check_val("in_ready", {31'd0, in_ready}, {31'd0, !(imem_we || done)});
  end

  // Driver: offer one byte after a random gap, hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int tries;
    gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    tries = 0;
    while (!in_ready && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 20) check_val("ready_timeout", 32'd1, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Send one frame of n words from fr_words; model the expected writes.
  task automatic run_frame(input int n, input bit bad_cs, input int max_gap);
    logic [7:0] len;
    logic [7:0] cs;
    logic [7:0] a;
    int d0;
    int t;
    len = (n == 256) ? 8'd0 : n[7:0];
    cs  = len;
    for (int i = 0; i < n; i++) begin
      a = i[7:0];
      exp_q.push_back({a, fr_words[i]});
      exp_mem[i] = fr_words[i];
      exp_wr[i]  = 1'b1;
    end
    d0 = done_cnt;
    send_byte(8'hA5, max_gap);
    check_val("hold_rise", {31'd0, cpu_hold}, 32'd1);
    check_val("error_clear", {31'd0, error}, 32'd0);
    send_byte(len, max_gap);
    for (int i = 0; i < n; i++) begin
      send_byte(fr_words[i][15:8], max_gap);
      send_byte(fr_words[i][7:0], max_gap);
      cs = cs ^ fr_words[i][15:8] ^ fr_words[i][7:0];
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    if (bad_cs) send_byte(~cs, max_gap);
    else        send_byte(cs, max_gap);
`endif
    t = 0;
    while (!(done || error) && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (bad_cs) begin
      check_val("error_set", {31'd0, error}, 32'd1);
      repeat (3) @(negedge clk);
      check_val("error_sticky", {31'd0, error}, 32'd1);
      check_val("error_hold", {31'd0, cpu_hold}, 32'd1);
      check_val("error_ready", {31'd0, in_ready}, 32'd1);
      check_val("no_done", done_cnt - d0, 32'd0);
    end else begin
      check_val("done_seen", {31'd0, done}, 32'd1);
      check_val("done_hold", {31'd0, cpu_hold}, 32'd1);
      @(negedge clk);
      check_val("hold_drop", {31'd0, cpu_hold}, 32'd0);
      check_val("done_once", done_cnt - d0, 32'd1);
    end
    check_val("writes_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    done_cnt = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'd0;
    for (int i = 0; i < 256; i++) exp_wr[i] = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    check_val("rst_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst_we", {31'd0, imem_we}, 32'd0);
    check_val("rst_addr", {24'd0, imem_addr}, 32'd0);
    check_val("rst_wdata", {16'd0, imem_wdata}, 32'd0);
    check_val("rst_hold", {31'd0, cpu_hold}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_error", {31'd0, error}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed frame: two words 1234, ABCD (checksum 42 when enabled).
    fr_words[0] = 16'h1234;
    fr_words[1] = 16'hABCD;
    run_frame(2, 1'b0, 0);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Same frame with a bad checksum, then recovery by a good frame.
    run_frame(2, 1'b1, 0);
    send_byte(8'h33, 0);
    check_val("error_discard", {31'd0, error}, 32'd1);
    fr_words[0] = 16'h0F0F;
    fr_words[1] = 16'hA5A5;
    run_frame(2, 1'b0, 1);
`endif

    // Non-sync bytes in IDLE are discarded.
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h5A, 0);
    check_val("idle_hold", {31'd0, cpu_hold}, 32'd0);
    check_val("idle_ready", {31'd0, in_ready}, 32'd1);

    // Full 256-word frame, addresses 0..255, no write after wrap.
    for (int i = 0; i < 256; i++) fr_words[i] = 16'($urandom);
    run_frame(256, 1'b0, 0);
    repeat (4) @(negedge clk);
    check_val("wrap_no_extra", exp_q.size(), 32'd0);

    // Reset after the first write of a 3-word frame.
    fr_words[0] = 16'hBEEF;
    exp_q.push_back({8'd0, 16'hBEEF});
    exp_mem[0] = 16'hBEEF;
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hEF, 0);
    check_val("mid_we", {31'd0, imem_we}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("mid_rst_hold", {31'd0, cpu_hold}, 32'd0);
    check_val("mid_rst_we", {31'd0, imem_we}, 32'd0);
    check_val("mid_rst_error", {31'd0, error}, 32'd0);
    check_val("mid_rst_mem0", {16'd0, dut_mem[0]}, 32'h0000BEEF);
    check_val("mid_rst_drained", exp_q.size(), 32'd0);
    @(negedge clk);

    // Random frames with random gaps; occasional sync values in payload.
    for (int f = 0; f < 8; f++) begin
      int n;
      bit bad;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        fr_words[i] = 16'($urandom);
        if ($urandom_range(0, 3) == 0) fr_words[i][15:8] = 8'hA5;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      bad = ($urandom_range(0, 3) == 0);
`else
      bad = 1'b0;
`endif
      run_frame(n, bad, 3);
    end

    // Final memory image against the model.
    for (int a = 0; a < 256; a++) begin
      if (exp_wr[a]) check_val("mem_image", {16'd0, dut_mem[a]}, {16'd0, exp_mem[a]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
